// File: rtl/inv_power_correct.sv
// Almost-inverse correction: out = in_value * 2^-k mod PRIME, latency k+2 edges (ceil(k/2)+2 with INV_CORRECT_DUAL_STEP_EN).
// Backpressure: in_ready only in IDLE; in_valid while busy is dropped and latches the sticky ovf flag. Field macros: BW_GF, PRIME.

`ifndef BW_GF
`define BW_GF 256
`endif
`ifndef PRIME
`define PRIME 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
`endif

module inv_power_correct #(
    parameter int BW_K = 9
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              in_valid,
    input  logic [`BW_GF-1:0] in_value,
    input  logic [BW_K-1:0]   in_power,
    output logic              in_ready,
    output logic              out_valid,
    output logic [`BW_GF-1:0] out_value,
    output logic              ovf
);

    localparam logic [`BW_GF-1:0] PRIME_V = `PRIME;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [`BW_GF-1:0] acc;
    logic [BW_K-1:0]   cnt;
    logic [`BW_GF-1:0] acc_h1;

    // Exact halving mod PRIME: odd values get PRIME added first, carry kept in the extra bit.
    function automatic logic [`BW_GF-1:0] half_mod(input logic [`BW_GF-1:0] a);
        logic [`BW_GF:0] sum;
        sum = {1'b0, a} + (a[0] ? {1'b0, PRIME_V} : {(`BW_GF+1){1'b0}});
        return sum[`BW_GF:1];
    endfunction

    assign acc_h1   = half_mod(acc);
    assign in_ready = (state == S_IDLE);

`ifdef INV_CORRECT_DUAL_STEP_EN
    logic [`BW_GF-1:0] acc_h2;
    assign acc_h2 = half_mod(acc_h1);
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && (state != S_IDLE)) begin
                ovf <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        acc   <= in_value;
                        cnt   <= in_power;
                        state <= (in_power != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
`ifdef INV_CORRECT_DUAL_STEP_EN
                    // Odd k leaves a single halving for the final cycle.
                    if (cnt == BW_K'(1)) begin
                        acc   <= acc_h1;
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        acc <= acc_h2;
                        cnt <= cnt - BW_K'(2);
                        if (cnt == BW_K'(2)) begin
                            state <= S_DONE;
                        end
                    end
`else
                    acc <= acc_h1;
                    cnt <= cnt - BW_K'(1);
                    if (cnt == BW_K'(1)) begin
                        state <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    // Final reduction only matters for out-of-range input.
                    out_value <= (acc >= PRIME_V) ? (acc - PRIME_V) : acc;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
